// File: rtl/l2_arb_pkg.sv
// Shared types and default sizing for the L2 port arbiter.
package l2_arb_pkg;

  localparam int unsigned ADDR_W_DEF     = 32;
  localparam int unsigned LINE_W_DEF     = 128;
  localparam int unsigned STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/l2_arb_prio.sv
// Winner selection (D over I) with a saturating starve counter that lets a
// waiting I request through after STARVE_MAX consecutive D grants.
module l2_arb_prio
  import l2_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ic_req,
  input  logic       dc_req,
  input  logic       grant,
  output arb_owner_e winner_c
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_cnt_d;
  logic             starved_c;

  assign starved_c = (starve_cnt == CNT_W'(STARVE_MAX));

  always_comb begin
    winner_c = OWN_IC;
    if (dc_req && !(ic_req && starved_c)) winner_c = OWN_DC;
  end

  // Count D grants taken while I waits; any other grant clears the count.
  always_comb begin
    starve_cnt_d = starve_cnt;
    if (grant) begin
      if (winner_c == OWN_DC && ic_req) begin
        if (!starved_c) starve_cnt_d = starve_cnt + CNT_W'(1);
      end else begin
        starve_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) starve_cnt <= '0;
    else       starve_cnt <= starve_cnt_d;
  end

endmodule

// File: rtl/l2_port_arbiter.sv
// Single-transaction arbiter sharing the L2 port between the I-cache and
// D-cache miss paths. Define L2_ARB_PERF_EN to add grant/conflict counters.
module l2_port_arbiter
  import l2_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned LINE_W     = LINE_W_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ic_req_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  output logic [LINE_W-1:0] ic_rdata_o,
  output logic              ic_ack_o,
  input  logic              dc_req_i,
  input  logic              dc_we_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic [LINE_W-1:0] dc_wdata_i,
  output logic [LINE_W-1:0] dc_rdata_o,
  output logic              dc_ack_o,
  output logic              l2_req_o,
  output logic              l2_we_o,
  output logic [ADDR_W-1:0] l2_addr_o,
  output logic [LINE_W-1:0] l2_wdata_o,
  input  logic [LINE_W-1:0] l2_rdata_i,
  input  logic              l2_ack_i,
  output logic              busy_o
`ifdef L2_ARB_PERF_EN
  ,
  output logic [31:0]       perf_ic_grants_o,
  output logic [31:0]       perf_dc_grants_o,
  output logic [31:0]       perf_conflicts_o
`endif
);

  arb_state_e        state, state_d;
  arb_owner_e        owner, owner_d;
  arb_owner_e        winner_c;
  logic              grant_c;
  logic              req_d, we_d, ic_ack_d, dc_ack_d, busy_d;
  logic [ADDR_W-1:0] addr_d;
  logic [LINE_W-1:0] wdata_d, ic_rdata_d, dc_rdata_d;

  assign grant_c = (state == IDLE) && (ic_req_i || dc_req_i);

  l2_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .ic_req   (ic_req_i),
    .dc_req   (dc_req_i),
    .grant    (grant_c),
    .winner_c (winner_c)
  );

  // Next-state and next-output logic; the L2 fields double as the latch.
  always_comb begin
    state_d    = state;
    owner_d    = owner;
    req_d      = l2_req_o;
    we_d       = l2_we_o;
    addr_d     = l2_addr_o;
    wdata_d    = l2_wdata_o;
    ic_rdata_d = ic_rdata_o;
    dc_rdata_d = dc_rdata_o;
    ic_ack_d   = 1'b0;
    dc_ack_d   = 1'b0;
    case (state)
      IDLE: begin
        if (grant_c) begin
          state_d = ISSUE;
          owner_d = winner_c;
          req_d   = 1'b1;
          if (winner_c == OWN_DC) begin
            we_d    = dc_we_i;
            addr_d  = dc_addr_i;
            wdata_d = dc_wdata_i;
          end else begin
            we_d    = 1'b0;
            addr_d  = ic_addr_i;
            wdata_d = '0;
          end
        end
      end
      ISSUE: begin
        if (l2_ack_i) begin
          state_d = RESP;
          req_d   = 1'b0;
          if (owner == OWN_DC) begin
            dc_rdata_d = l2_rdata_i;
            dc_ack_d   = 1'b1;
          end else begin
            ic_rdata_d = l2_rdata_i;
            ic_ack_d   = 1'b1;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      owner      <= OWN_IC;
      l2_req_o   <= 1'b0;
      l2_we_o    <= 1'b0;
      l2_addr_o  <= '0;
      l2_wdata_o <= '0;
      ic_rdata_o <= '0;
      dc_rdata_o <= '0;
      ic_ack_o   <= 1'b0;
      dc_ack_o   <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      state      <= state_d;
      owner      <= owner_d;
      l2_req_o   <= req_d;
      l2_we_o    <= we_d;
      l2_addr_o  <= addr_d;
      l2_wdata_o <= wdata_d;
      ic_rdata_o <= ic_rdata_d;
      dc_rdata_o <= dc_rdata_d;
      ic_ack_o   <= ic_ack_d;
      dc_ack_o   <= dc_ack_d;
      busy_o     <= busy_d;
    end
  end

`ifdef L2_ARB_PERF_EN
  // Free-running wrap-around event counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_ic_grants_o <= '0;
      perf_dc_grants_o <= '0;
      perf_conflicts_o <= '0;
    end else begin
      if (grant_c && winner_c == OWN_IC) perf_ic_grants_o <= perf_ic_grants_o + 32'd1;
      if (grant_c && winner_c == OWN_DC) perf_dc_grants_o <= perf_dc_grants_o + 32'd1;
      if (state == IDLE && ic_req_i && dc_req_i) perf_conflicts_o <= perf_conflicts_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Self-checking bench for l2_port_arbiter: directed vector table, fixed
// corner-case sequences and randomized traffic against a behavioural model.
module tb_l2_port_arbiter;

  localparam int SM = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         ic_req, dc_req, dc_we, l2_ack;
  logic [31:0]  ic_addr, dc_addr;
  logic [127:0] dc_wdata, l2_rdata;
  logic [127:0] ic_rdata, dc_rdata, l2_wdata;
  logic         ic_ack, dc_ack, l2_req, l2_we, busy;
  logic [31:0]  l2_addr;
`ifdef L2_ARB_PERF_EN
  logic [31:0]  perf_ic, perf_dc, perf_conf;
`endif

  always #5 clk = ~clk;

  l2_port_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .ic_req_i(ic_req), .ic_addr_i(ic_addr), .ic_rdata_o(ic_rdata), .ic_ack_o(ic_ack),
    .dc_req_i(dc_req), .dc_we_i(dc_we), .dc_addr_i(dc_addr), .dc_wdata_i(dc_wdata),
    .dc_rdata_o(dc_rdata), .dc_ack_o(dc_ack),
    .l2_req_o(l2_req), .l2_we_o(l2_we), .l2_addr_o(l2_addr), .l2_wdata_o(l2_wdata),
    .l2_rdata_i(l2_rdata), .l2_ack_i(l2_ack), .busy_o(busy)
`ifdef L2_ARB_PERF_EN
    , .perf_ic_grants_o(perf_ic), .perf_dc_grants_o(perf_dc), .perf_conflicts_o(perf_conf)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int           d_streak;
  logic [127:0] last_ic, last_dc;
  int           m_icg, m_dcg, m_conf;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // D wins unless I is also waiting and D has already had SM grants in a row.
  function automatic logic predict_dc(input logic ic, input logic dc);
    return dc && !(ic && d_streak == SM);
  endfunction

  task automatic model_reset();
    d_streak = 0; last_ic = '0; last_dc = '0;
    m_icg = 0; m_dcg = 0; m_conf = 0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      ic_req = 1'b0; dc_req = 1'b0; l2_ack = 1'($urandom_range(0, 1));
      step();
      chk("idle_busy", busy, 0);
      chk("idle_l2_req", l2_req, 0);
      chk("idle_acks", {ic_ack, dc_ack}, 0);
    end
  endtask

  // One full transaction; entered and left in an IDLE cycle.
  task automatic run_txn(input logic ic, input logic dc, input logic we,
                         input logic [31:0] ia, input logic [31:0] da,
                         input logic [127:0] wd, input logic [127:0] rd,
                         input int dly, input logic exp_dc);
    int busy_cnt;
    logic [31:0]  e_addr;
    logic [127:0] e_wdata;
    logic         e_we;
    e_addr  = exp_dc ? da : ia;
    e_wdata = exp_dc ? wd : '0;
    e_we    = exp_dc ? we : 1'b0;
    ic_req = ic; dc_req = dc; dc_we = we; ic_addr = ia; dc_addr = da; dc_wdata = wd;
    l2_ack = 1'($urandom_range(0, 1));
    if (ic && dc) m_conf++;
    if (exp_dc) m_dcg++; else m_icg++;
    if (exp_dc && ic) d_streak = (d_streak < SM) ? d_streak + 1 : SM;
    else d_streak = 0;
    step();
    busy_cnt = 0;
    for (int k = 0; k <= dly; k++) begin
      chk("issue_l2_req", l2_req, 1);
      chk("issue_l2_we", l2_we, e_we);
      chk("issue_l2_addr", l2_addr, e_addr);
      chk("issue_l2_wdata", l2_wdata, e_wdata);
      chk("issue_acks", {ic_ack, dc_ack}, 0);
      if (busy) busy_cnt++;
      if (exp_dc) ic_addr = $urandom;
      else begin dc_addr = $urandom; dc_wdata = rnd128(); dc_we = 1'($urandom_range(0, 1)); end
      l2_ack   = (k == dly);
      l2_rdata = (k == dly) ? rd : rnd128();
      step();
    end
    l2_ack = 1'($urandom_range(0, 1)); l2_rdata = rnd128();
    chk("resp_ic_ack", ic_ack, !exp_dc);
    chk("resp_dc_ack", dc_ack, exp_dc);
    if (exp_dc) last_dc = rd; else last_ic = rd;
    chk("resp_ic_rdata", ic_rdata, last_ic);
    chk("resp_dc_rdata", dc_rdata, last_dc);
    chk("resp_l2_req", l2_req, 0);
    if (busy) busy_cnt++;
    if (exp_dc) dc_req = 1'b0; else ic_req = 1'b0;
    step();
    chk("post_acks", {ic_ack, dc_ack}, 0);
    chk("post_busy", busy, 0);
    chk("busy_cycles", 128'(busy_cnt), 128'(dly + 2));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ic"}, {ic_ack, ic_rdata}, 0);
    chk({tag, "_dc"}, {dc_ack, dc_rdata}, 0);
    chk({tag, "_l2"}, {l2_req, l2_we, l2_addr, l2_wdata}, 0);
    chk({tag, "_busy"}, busy, 0);
`ifdef L2_ARB_PERF_EN
    chk({tag, "_perf"}, {perf_ic, perf_dc, perf_conf}, 0);
`endif
  endtask

  typedef struct {
    logic         ic, dc, we;
    logic [31:0]  ia, da;
    logic [127:0] wd, rd;
    int           dly;
    logic         exp_dc;
  } vec_t;

  initial begin
    vec_t vecs[5];
    logic order_dc[10];
    logic ic, dc, e;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_1000, 32'h0, 128'h0, {16{8'hA5}}, 3, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_2040,
                128'h1234_5678_9ABC_DEF0_0BAD_F00D_CAFE_BEEF, 128'h77, 1, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_3000, 128'h0, {16{8'h5A}}, 0, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h0000_4000, 32'h0000_5000, 128'h0, 128'hC0FFEE, 2, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h0000_6000, 32'h0, 128'h0, 128'hFACE, 0, 1'b0};
    order_dc = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    rst = 1'b1; ic_req = 0; dc_req = 0; dc_we = 0; l2_ack = 0;
    ic_addr = '0; dc_addr = '0; dc_wdata = '0; l2_rdata = '0;
    model_reset();
    step(); step();
    chk_all_zero("reset");
    rst = 1'b0;
    idle_cycles(2);

    foreach (vecs[i])
      run_txn(vecs[i].ic, vecs[i].dc, vecs[i].we, vecs[i].ia, vecs[i].da,
              vecs[i].wd, vecs[i].rd, vecs[i].dly, vecs[i].exp_dc);

    // Reset during ISSUE drops the transaction without an ack.
    ic_req = 1'b0; dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h7000; dc_wdata = rnd128();
    l2_ack = 1'b0;
    step();
    chk("midrst_issue", l2_req, 1);
    rst = 1'b1;
    step();
    chk_all_zero("midrst");
    model_reset();
    rst = 1'b0;
    run_txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h7000, 128'h1111, 128'h2222, 0, 1'b1);

    // Both held pending with immediate L2 acks: anti-starvation order.
    for (int i = 0; i < 10; i++)
      run_txn(1'b1, 1'b1, 1'b0, 32'h8000 + 32'(i), 32'h9000 + 32'(i), 128'h0,
              rnd128(), 0, order_dc[i]);

    // Randomized traffic against the model.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) == 0) idle_cycles($urandom_range(1, 3));
      else begin
        case ($urandom_range(0, 2))
          0:       begin ic = 1'b1; dc = 1'b0; end
          1:       begin ic = 1'b0; dc = 1'b1; end
          default: begin ic = 1'b1; dc = 1'b1; end
        endcase
        e = predict_dc(ic, dc);
        run_txn(ic, dc, 1'($urandom_range(0, 1)), $urandom, $urandom, rnd128(), rnd128(),
                $urandom_range(0, 3), e);
      end
    end

`ifdef L2_ARB_PERF_EN
    chk("perf_ic_model", perf_ic, m_icg);
    chk("perf_dc_model", perf_dc, m_dcg);
    chk("perf_conf_model", perf_conf, m_conf);
    rst = 1'b1; step(); rst = 1'b0; model_reset();
    for (int i = 0; i < 3; i++) begin
      run_txn(1'b1, 1'b1, 1'b0, 32'hA000, 32'hB000, 128'h0, rnd128(), 0, 1'b1);
      run_txn(1'b1, 1'b0, 1'b0, 32'hA000, 32'h0, 128'h0, rnd128(), 1, 1'b0);
    end
    chk("perf_ic_3", perf_ic, 3);
    chk("perf_dc_3", perf_dc, 3);
    chk("perf_conf_3", perf_conf, 3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/l2_port_arbiter.md
Name: l2_port_arbiter

Overview:
- Shares the single L2 cache port between the L1 I-cache miss path and the L1 D-cache miss/writeback path in the two-level 4-way cache hierarchy.
- Serves one transaction at a time.
- Fixed D-over-I priority, with an anti-starvation override for the I-cache.
- Latches the winning request, drives the L2 port until acknowledged, then returns data and a one-cycle ack to the winner.

Parameters:
- ADDR_W, 32, byte address width.
- LINE_W, 128, cache line width (4 words).
- STARVE_MAX, 4, consecutive D grants allowed while an I request is pending; must be ≥1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- ic_req_i  in  1  I-cache line-fill request; held until ic_ack_o.
- ic_addr_i  in  ADDR_W  I-cache line address.
- ic_rdata_o  out  LINE_W  fill data; valid when ic_ack_o=1.
- ic_ack_o  out  1  one-cycle completion pulse.
- dc_req_i  in  1  D-cache request; held until dc_ack_o.
- dc_we_i  in  1  1 = writeback, 0 = fill.
- dc_addr_i  in  ADDR_W  D-cache line address.
- dc_wdata_i  in  LINE_W  writeback data.
- dc_rdata_o  out  LINE_W  fill data; valid when dc_ack_o=1.
- dc_ack_o  out  1  one-cycle completion pulse.
- l2_req_o  out  1  L2 request; held until l2_ack_i.
- l2_we_o  out  1  L2 write enable.
- l2_addr_o  out  ADDR_W  L2 address.
- l2_wdata_o  out  LINE_W  L2 write data.
- l2_rdata_i  in  LINE_W  L2 read data; valid with l2_ack_i.
- l2_ack_i  in  1  L2 completion pulse.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0; FSM=IDLE; starve counter=0; latched addr/wdata/we/owner=0.
- Reset mid-transaction: the transaction is dropped and no ack is issued. The L2 must tolerate l2_req_o falling early.
- FSM states: IDLE, ISSUE, RESP.
- IDLE: if any request is pending, select a winner and latch owner, addr, we and wdata (we=0 and wdata=0 for I). Go to ISSUE.
- Winner selection:
  - Only one request pending: that requester wins.
  - Both pending, starve_cnt==STARVE_MAX: I wins.
  - Both pending, otherwise: D wins.
- ISSUE: l2_req_o=1 with the latched fields held stable.
  - l2_ack_i=1: capture l2_rdata_i into the owner's rdata register, go to RESP.
  - l2_ack_i=1 in the first ISSUE cycle is legal.
- RESP: owner's ack_o=1 for exactly this cycle, rdata_o valid. Return to IDLE.
- Non-owner ack and rdata: ack stays 0; rdata holds its last value.
- Minimum latency: request sampled in IDLE at cycle N → l2_req_o at N+1 → ack_o at N+2 if L2 acks at N+1.
- Requesters drop req on the edge after seeing ack. IDLE therefore never re-serves a completed request.
- Starve counter (saturating):
  - Increments on a D grant while ic_req_i=1.
  - Clears on any I grant, and on any grant while ic_req_i=0.
- Requests arriving during ISSUE/RESP wait; they are not latched early.
- Requester inputs are sampled only in IDLE. Changes during ISSUE do not affect the L2 port.
- l2_ack_i outside ISSUE is ignored.

Optional Feature:
- Macro: L2_ARB_PERF_EN.
- Defined: adds outputs perf_ic_grants_o[31:0], perf_dc_grants_o[31:0] and perf_conflicts_o[31:0].
  - Conflicts counter: cycles in IDLE with both requests pending.
  - All three wrap at 2^32 and reset to 0.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package l2_arb_pkg:
  - enum arb_state_e {IDLE, ISSUE, RESP}.
  - enum arb_owner_e {OWN_IC, OWN_DC}.
  - Default constants for LINE_W, ADDR_W, STARVE_MAX.
- One natural sub-module: l2_arb_prio. It is combinational winner selection plus the registered starve counter.

Test Plan:
- Lone I request, addr 0x0000_1000; L2 acks after 3 ISSUE cycles with 128'hA5..A5 → ic_ack_o pulses once, ic_rdata_o=A5..A5, dc_ack_o stays 0, busy_o high for 5 cycles.
- D writeback at 0x0000_2040 with wdata 128'h1234_5678_9ABC_DEF0_0BAD_F00D_CAFE_BEEF → l2_we_o=1, l2_wdata_o matches exactly, dc_ack_o pulses once.
- I and D held pending continuously, STARVE_MAX=4, L2 acks immediately → grant order D,D,D,D,I,D,D,D,D,I.
- L2 acks in the first ISSUE cycle → ack_o exactly 2 cycles after the request is sampled in IDLE.
- rst_i asserted during ISSUE → next cycle all outputs 0 and FSM IDLE; after release, the re-asserted request completes normally.
- L2_ARB_PERF_EN defined, 3 simultaneous I+D requests → perf_dc_grants_o=3, perf_ic_grants_o=3 after all complete, perf_conflicts_o≥3.
